// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the program-counter sequencer: FSM state encodings and
// next-PC source selection in strobe-priority order (RET > CALL > JMP/branch > step).
package pc_sequencer_pkg;

  localparam logic [0:0] PCS_RUN  = 1'b0;
  localparam logic [0:0] PCS_HALT = 1'b1;

  localparam logic [1:0] SEL_STEP   = 2'd0;
  localparam logic [1:0] SEL_TARGET = 2'd1;
  localparam logic [1:0] SEL_CALL   = 2'd2;
  localparam logic [1:0] SEL_RET    = 2'd3;

  // Resolve simultaneous strobes; lower-priority strobes are dropped.
  function automatic logic [1:0] pick_sel(input logic jump, input logic branch_taken,
                                          input logic call, input logic ret);
    logic [1:0] sel;
    if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (jump || branch_taken) begin
      sel = SEL_TARGET;
    end else begin
      sel = SEL_STEP;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return-address LIFO. A push while full overwrites the oldest entry
// (sp wraps) and the occupancy count saturates at DEPTH.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] sp_r;
  logic [PTR_W:0]   count_r;

  // Pointer, occupancy and storage update; push wins if both are requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r    <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push) begin
      mem_r[sp_r] <= push_data;
      sp_r        <= sp_r + PTR_W'(1);
      if (!full) begin
        count_r <= count_r + (PTR_W + 1)'(1);
      end else begin
        count_r <= count_r;
      end
    end else if (pop && !empty) begin
      sp_r    <= sp_r - PTR_W'(1);
      count_r <= count_r - (PTR_W + 1)'(1);
    end else begin
      sp_r    <= sp_r;
      count_r <= count_r;
    end
  end

  assign top   = mem_r[sp_r - PTR_W'(1)];
  assign depth = count_r;
  assign full  = (count_r == (PTR_W + 1)'(DEPTH));
  assign empty = (count_r == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer driving the instruction ROM address, with CALL/RET
// return stack. Optional macro PC_SEQ_FAULT_HALT_EN turns stack faults into a HALT state.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          jump,
  input  logic                          branch_taken,
  input  logic                          call,
  input  logic                          ret,
  input  logic [ADDR_W-1:0]             target,
  output logic [ADDR_W-1:0]             address,
  output logic [$clog2(STACK_DEPTH):0]  depth,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          halted
);

  logic [ADDR_W-1:0] pc_r;
  logic [0:0]        state_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] top_s;
  logic [0:0]        next_state_s;
  logic              push_s;
  logic              pop_s;
  logic              set_ovf_s;
  logic              set_udf_s;
  logic              full_s;
  logic              empty_s;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top       (top_s),
    .depth     (depth),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign pc_inc_s = pc_r + ADDR_W'(1);

  // Next-PC mux, stack control and fault detection.
  always_comb begin
    next_pc_s    = pc_r;
    next_state_s = state_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    set_ovf_s    = 1'b0;
    set_udf_s    = 1'b0;
    case (state_r)
      PCS_RUN: begin
        if (!stall) begin
          case (pick_sel(jump, branch_taken, call, ret))
            SEL_RET: begin
              if (empty_s) begin
                set_udf_s = 1'b1;
`ifdef PC_SEQ_FAULT_HALT_EN
                next_state_s = PCS_HALT;
`else
                next_pc_s = RESET_VECTOR;
`endif
              end else begin
                next_pc_s = top_s;
                pop_s     = 1'b1;
              end
            end
            SEL_CALL: begin
              if (full_s) begin
                set_ovf_s = 1'b1;
`ifdef PC_SEQ_FAULT_HALT_EN
                next_state_s = PCS_HALT;
`else
                push_s    = 1'b1;
                next_pc_s = target;
`endif
              end else begin
                push_s    = 1'b1;
                next_pc_s = target;
              end
            end
            SEL_TARGET: next_pc_s = target;
            SEL_STEP:   next_pc_s = pc_inc_s;
            default:    next_pc_s = pc_r;
          endcase
        end else begin
          next_pc_s = pc_r;
        end
      end
      PCS_HALT: next_pc_s = pc_r;
      default:  next_state_s = PCS_HALT;
    endcase
  end

  // PC, state and sticky fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= RESET_VECTOR;
      state_r     <= PCS_RUN;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pc_r        <= next_pc_s;
      state_r     <= next_state_s;
      overflow_r  <= overflow_r | set_ovf_s;
      underflow_r <= underflow_r | set_udf_s;
    end
  end

  assign address   = pc_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`ifdef PC_SEQ_FAULT_HALT_EN
  assign halted = (state_r == PCS_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for single-cycle behaviour and
// hand sequences for nesting, faults, async reset and address wrap.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic        branch_taken;
  logic        call;
  logic        ret;
  logic [15:0] target;
  logic [15:0] address;
  logic [3:0]  depth;
  logic        overflow;
  logic        underflow;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .ADDR_W       (16),
    .STACK_DEPTH  (8),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jump         (jump),
    .branch_taken (branch_taken),
    .call         (call),
    .ret          (ret),
    .target       (target),
    .address      (address),
    .depth        (depth),
    .overflow     (overflow),
    .underflow    (underflow),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s, j, b, c, r;
    logic [15:0] tgt;
    logic [15:0] exp_addr;
    logic [3:0]  exp_depth;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic s, input logic j, input logic b, input logic c,
                              input logic r, input logic [15:0] tgt, input logic [15:0] ea,
                              input logic [3:0] ed, input logic eo, input logic eu);
    vec_t v;
    v.s = s; v.j = j; v.b = b; v.c = c; v.r = r; v.tgt = tgt;
    v.exp_addr = ea; v.exp_depth = ed; v.exp_ovf = eo; v.exp_udf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Apply one cycle of strobes and sample #1 after the edge.
  task automatic drive(input logic s, input logic j, input logic b, input logic c,
                       input logic r, input logic [15:0] tgt);
    stall = s; jump = j; branch_taken = b; call = c; ret = r; target = tgt;
    @(posedge clk);
    #1;
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
    target = 16'h0000;
    rst_n = 1'b0;

    //            s     j     b     c     r     tgt      addr     d     ovf   udf
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd1,  4'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd2,  4'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd3,  4'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd4,  4'd0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7,  16'd7,  4'd1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd8,  4'd1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  16'd5,  4'd0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd6,  4'd0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9,  16'd9,  4'd1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd30, 16'd7,  4'd0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd12, 16'd12, 4'd0, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd40, 16'd12, 4'd0, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd40, 16'd12, 4'd0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd40, 16'd12, 4'd0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  16'd12, 4'd0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd13, 4'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_addr", address, 16'd0);
    chk("reset_depth", depth, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_udf", underflow, 0);
    chk("reset_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_addr", address, 16'd0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].j, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].tgt);
      chk($sformatf("vec%0d_addr", i), address, tbl[i].exp_addr);
      chk($sformatf("vec%0d_depth", i), depth, tbl[i].exp_depth);
      chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].exp_ovf);
      chk($sformatf("vec%0d_udf", i), underflow, tbl[i].exp_udf);
    end

    // Nine nested calls from PC=13; call i jumps to 20+2i, pushing 14,21,23,...,35.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(20 + 2 * i));
`ifdef PC_SEQ_FAULT_HALT_EN
      chk($sformatf("nest%0d_addr", i), address, (i < 8) ? 20 + 2 * i : 34);
`else
      chk($sformatf("nest%0d_addr", i), address, 20 + 2 * i);
`endif
      chk($sformatf("nest%0d_depth", i), depth, (i < 8) ? i + 1 : 8);
      chk($sformatf("nest%0d_ovf", i), overflow, (i == 8) ? 1 : 0);
    end

`ifdef PC_SEQ_FAULT_HALT_EN
    chk("ovf_halted", halted, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    chk("halt_ret_addr", address, 34);
    chk("halt_ret_depth", depth, 8);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd99);
    chk("halt_jmp_addr", address, 34);
    do_reset();
    chk("rst_after_halt", halted, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    chk("udf_flag", underflow, 1);
    chk("udf_halted", halted, 1);
    chk("udf_addr", address, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("udf_hold_addr", address, 0);
`else
    chk("ovf_halted", halted, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      chk($sformatf("unwind%0d_addr", k), address, 35 - 2 * k);
      chk($sformatf("unwind%0d_depth", k), depth, 7 - k);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    chk("udf_flag", underflow, 1);
    chk("udf_addr", address, 0);
    chk("udf_depth", depth, 0);
    chk("udf_halted", halted, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd0);
    chk("after_udf_addr", address, 1);
    chk("ovf_sticky", overflow, 1);
    chk("udf_sticky", underflow, 1);
`endif

    // Asynchronous reset asserted mid-cycle, checked before the next edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_addr", address, 0);
    chk("async_rst_depth", depth, 0);
    chk("async_rst_ovf", overflow, 0);
    chk("async_rst_udf", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Address wrap and CALL at the last address.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    chk("jmp_ffff", address, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("wrap_addr", address, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    chk("br_ffff", address, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd50);
    chk("call_ffff_addr", address, 50);
    chk("call_ffff_depth", depth, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    chk("ret_to_zero", address, 0);
    chk("ret_to_zero_depth", depth, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
